// File: rtl/lc3_mio_sequencer.sv
// LC-3 memory/MMIO access sequencer: wait-stated memory cycles, per-channel keyboard/display
// registers with valid/ready handshakes, and registered interrupt generation.
module lc3_mio_sequencer #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       N_CH      = 2,
  parameter int unsigned       MEM_WAIT  = 2,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFE00
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_mio_en,
  input  logic                i_rw,
  input  logic [ADDR_W-1:0]   i_mar,
  input  logic [DATA_W-1:0]   i_mdr,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_r,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic [N_CH-1:0]     i_in_valid,
  input  logic [8*N_CH-1:0]   i_in_data,
  output logic [N_CH-1:0]     o_in_ready,
  output logic [N_CH-1:0]     o_out_valid,
  output logic [8*N_CH-1:0]   o_out_data,
  input  logic [N_CH-1:0]     i_out_ready,
  output logic [N_CH-1:0]     o_irq
);

  localparam int unsigned       ChW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam longint unsigned   WinEnd  = longint'(MMIO_BASE) + 8 * longint'(N_CH);
  localparam logic [ADDR_W-1:0] WinSize = ADDR_W'(8 * N_CH);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("N_CH must be in 1..8");
  end
  if (MEM_WAIT > 15) begin : g_bad_wait
    $error("MEM_WAIT must be in 0..15");
  end
  if (DATA_W < 16) begin : g_bad_dw
    $error("DATA_W must be at least 16");
  end
  if (WinEnd > (64'd1 << ADDR_W)) begin : g_bad_win
    $error("MMIO window exceeds the address space");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rw_q, mmio_q;
  logic [ChW-1:0]      chan_q;
  logic [1:0]          sel_q;
  logic [DATA_W-1:0]   rdata_q, mmio_rdata;
  logic                acc_last, in_access, mmio_fire;

  logic [N_CH-1:0]        kb_rdy_v, kb_ie_v, ds_rdy_v, ds_ie_v, irq_v;
  logic [N_CH-1:0][7:0]   kbdr_v, ddr_v;

  // Request decode; offset is computed in ADDR_W bits, window never wraps.
  logic [ADDR_W-1:0] mar_off;
  logic              req_mmio;
  assign mar_off  = i_mar - MMIO_BASE;
  assign req_mmio = (i_mar >= MMIO_BASE) && (mar_off < WinSize);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    acc_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_mio_en) begin
          state_d = StAccess;
          wait_d  = '0;
        end
      end
      StAccess: begin
        acc_last = mmio_q || (wait_q == 4'(MEM_WAIT));
        if (acc_last) state_d = StDone;
        else          wait_d  = wait_q + 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_access   = (state_q == StAccess);
  assign mmio_fire   = in_access & mmio_q;
  assign o_r         = (state_q == StDone);
  assign o_mem_en    = in_access & ~mmio_q;
  assign o_mem_we    = o_mem_en & rw_q & acc_last;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_rdata     = rdata_q;

  always_comb begin
    mmio_rdata = '0;
    unique case (sel_q)
      2'd0: mmio_rdata = {kb_rdy_v[chan_q], kb_ie_v[chan_q], (DATA_W-2)'(0)};
      2'd1: mmio_rdata = {(DATA_W-8)'(0), kbdr_v[chan_q]};
      2'd2: mmio_rdata = {ds_rdy_v[chan_q], ds_ie_v[chan_q], (DATA_W-2)'(0)};
      2'd3: mmio_rdata = {(DATA_W-8)'(0), ddr_v[chan_q]};
      default: mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      mmio_q  <= 1'b0;
      chan_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == StIdle && i_mio_en) begin
        addr_q  <= i_mar;
        wdata_q <= i_mdr;
        rw_q    <= i_rw;
        mmio_q  <= req_mmio;
        chan_q  <= mar_off[ChW+2:3];
        sel_q   <= mar_off[2:1];
      end
      if (acc_last && !rw_q) begin
        rdata_q <= mmio_q ? mmio_rdata : i_mem_rdata;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic       hit;
    logic       kb_rdy_q, kb_ie_q, ds_rdy_q, ds_ie_q, irq_q;
    logic [7:0] kbdr_q, ddr_q;

    assign hit = mmio_fire && (chan_q == ChW'(c));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        kb_rdy_q <= 1'b0;
        kb_ie_q  <= 1'b0;
        kbdr_q   <= '0;
        ds_rdy_q <= 1'b1;
        ds_ie_q  <= 1'b0;
        ddr_q    <= '0;
        irq_q    <= 1'b0;
      end else begin
        // Accept only when empty, so a same-cycle KBDR read clear is a no-op here.
        if (i_in_valid[c] && !kb_rdy_q) begin
          kbdr_q   <= i_in_data[8*c +: 8];
          kb_rdy_q <= 1'b1;
        end else if (hit && !rw_q && sel_q == 2'd1) begin
          kb_rdy_q <= 1'b0;
        end
        if (hit && rw_q && sel_q == 2'd0) kb_ie_q <= wdata_q[DATA_W-2];

        if (hit && rw_q && sel_q == 2'd3 && ds_rdy_q) begin
          ddr_q    <= wdata_q[7:0];
          ds_rdy_q <= 1'b0;
        end else if (!ds_rdy_q && i_out_ready[c]) begin
          ds_rdy_q <= 1'b1;
        end
        if (hit && rw_q && sel_q == 2'd2) ds_ie_q <= wdata_q[DATA_W-2];

        irq_q <= (kb_rdy_q & kb_ie_q) | (ds_rdy_q & ds_ie_q);
      end
    end

    assign kb_rdy_v[c] = kb_rdy_q;
    assign kb_ie_v[c]  = kb_ie_q;
    assign kbdr_v[c]   = kbdr_q;
    assign ds_rdy_v[c] = ds_rdy_q;
    assign ds_ie_v[c]  = ds_ie_q;
    assign ddr_v[c]    = ddr_q;
    assign irq_v[c]    = irq_q;
  end

  assign o_in_ready  = ~kb_rdy_v;
  assign o_out_valid = ~ds_rdy_v;
  assign o_out_data  = ddr_v;
  assign o_irq       = irq_v;

endmodule

// File: tb/tb_lc3_mio_sequencer.sv
// Randomized bench for lc3_mio_sequencer against a transaction-level register/memory model.
module tb_lc3_mio_sequencer;

  localparam int          MW   = 2;
  localparam int          NC   = 2;
  localparam logic [15:0] BASE = 16'hFE00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mio_en = 1'b0, rw = 1'b0;
  logic [15:0]   mar = '0, mdr = '0;
  logic [15:0]   rdata;
  logic          r_out, mem_en, mem_we;
  logic [15:0]   mem_addr, mem_wdata, mem_rdata;
  logic [NC-1:0] in_valid = '0, in_ready, out_valid, out_ready = '0, irq;
  logic [8*NC-1:0] in_data = '0, out_data;

  logic [15:0] tb_mem [0:65535];

  always #5 clk = ~clk;

  lc3_mio_sequencer #(
    .DATA_W(16), .ADDR_W(16), .N_CH(NC), .MEM_WAIT(MW), .MMIO_BASE(BASE)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_mio_en(mio_en), .i_rw(rw), .i_mar(mar), .i_mdr(mdr),
    .o_rdata(rdata), .o_r(r_out), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready), .o_irq(irq)
  );

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;

  // Reference model state
  bit          m_kb_rdy [NC], m_kb_ie [NC], m_ds_rdy [NC], m_ds_ie [NC];
  logic [7:0]  m_kbdr [NC], m_ddr [NC];
  logic [15:0] ref_mem [int];
  logic [15:0] m_rdata;
  int          pend_ch = -1;
  logic [7:0]  pend_char;

  int n_cmp = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_kb_rdy[c] = 0; m_kb_ie[c] = 0; m_ds_rdy[c] = 1; m_ds_ie[c] = 0;
      m_kbdr[c] = '0;  m_ddr[c] = '0;
    end
    m_rdata = '0;
  endtask

  function automatic bit is_mmio(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 8 * NC);
  endfunction

  // Idle one cycle, then compare every handshake/irq output with the model.
  task automatic check_state();
    logic [NC-1:0]   e_rdy, e_val, e_irq;
    logic [8*NC-1:0] e_dat;
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) begin
      e_rdy[c] = !m_kb_rdy[c];
      e_val[c] = !m_ds_rdy[c];
      e_irq[c] = (m_kb_rdy[c] & m_kb_ie[c]) | (m_ds_rdy[c] & m_ds_ie[c]);
      e_dat[8*c +: 8] = m_ddr[c];
    end
    check_val("in_ready", 32'(in_ready), 32'(e_rdy));
    check_val("out_valid", 32'(out_valid), 32'(e_val));
    check_val("out_data", 32'(out_data), 32'(e_dat));
    check_val("irq", 32'(irq), 32'(e_irq));
    check_val("idle_r", 32'(r_out), 0);
    check_val("idle_mem_en", 32'(mem_en), 0);
  endtask

  task automatic run_op(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] got);
    int ch, rg, lat, en_cyc, we_cyc, exp_lat;
    bit mm;
    logic [15:0] exp_rd;
    mm = is_mmio(addr);
    exp_rd = m_rdata;
    if (mm) begin
      ch = (int'(addr) - int'(BASE)) / 8;
      rg = ((int'(addr) - int'(BASE)) % 8) / 2;
      if (!wr) begin
        case (rg)
          0: exp_rd = {m_kb_rdy[ch], m_kb_ie[ch], 14'b0};
          1: begin exp_rd = {8'h00, m_kbdr[ch]}; m_kb_rdy[ch] = 0; end
          2: exp_rd = {m_ds_rdy[ch], m_ds_ie[ch], 14'b0};
          default: exp_rd = {8'h00, m_ddr[ch]};
        endcase
      end else begin
        case (rg)
          0: m_kb_ie[ch] = wd[14];
          2: m_ds_ie[ch] = wd[14];
          3: if (m_ds_rdy[ch]) begin m_ddr[ch] = wd[7:0]; m_ds_rdy[ch] = 0; end
          default: ;
        endcase
      end
      exp_lat = 2;
    end else begin
      if (!wr) exp_rd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0000;
      else ref_mem[int'(addr)] = wd;
      exp_lat = MW + 2;
    end
    if (!wr) m_rdata = exp_rd;

    mio_en = 1'b1; rw = wr; mar = addr; mdr = wd;
    @(posedge clk); #1;
    lat = 1; en_cyc = 0; we_cyc = 0;
    while (!r_out && lat < 40) begin
      en_cyc += int'(mem_en);
      we_cyc += int'(mem_we);
      @(posedge clk); #1;
      lat++;
    end
    got = rdata;
    mio_en = 1'b0;
    check_val("latency", lat, exp_lat);
    check_val("rdata", 32'(got), 32'(exp_rd));
    check_val("mem_en_cycles", en_cyc, mm ? 0 : MW + 1);
    check_val("mem_we_cycles", we_cyc, (!mm && wr) ? 1 : 0);
    @(posedge clk); #1;
    if (pend_ch >= 0 && !m_kb_rdy[pend_ch]) begin
      in_valid[pend_ch] = 1'b0;
      m_kb_rdy[pend_ch] = 1;
      m_kbdr[pend_ch] = pend_char;
      pend_ch = -1;
    end
    check_state();
  endtask

  task automatic inject(input int ch, input logic [7:0] chr);
    in_valid[ch] = 1'b1;
    in_data[8*ch +: 8] = chr;
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
    if (!m_kb_rdy[ch]) begin m_kb_rdy[ch] = 1; m_kbdr[ch] = chr; end
    check_state();
  endtask

  task automatic drain(input int ch);
    out_ready[ch] = 1'b1;
    @(posedge clk); #1;
    out_ready[ch] = 1'b0;
    m_ds_rdy[ch] = 1;
    check_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    bit saw_r;
    for (int i = 0; i < 65536; i++) tb_mem[i] = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_r", 32'(r_out), 0);
    check_val("rst_mem_en", 32'(mem_en), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_rdata", 32'(rdata), 0);
    check_val("rst_mem_we", 32'(mem_we), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_irq", 32'(irq), 0);
    check_val("rst_in_ready", 32'(in_ready), 32'({NC{1'b1}}));

    // Memory write/read with wait states
    run_op(1, 16'h3000, 16'h1234, got);
    run_op(0, 16'h3000, 16'h0000, got);
    check_val("mem_readback", 32'(got), 32'h1234);

    // Keyboard channel 0
    inject(0, 8'h41);
    check_val("kb0_busy", 32'(in_ready[0]), 0);
    run_op(0, 16'hFE00, 0, got); check_val("kbsr_full", 32'(got), 32'h8000);
    run_op(0, 16'hFE02, 0, got); check_val("kbdr_char", 32'(got), 32'h0041);
    run_op(0, 16'hFE00, 0, got); check_val("kbsr_empty", 32'(got), 32'h0000);
    check_val("kb0_ready", 32'(in_ready[0]), 1);

    // Display channel 1
    run_op(1, 16'hFE0E, 16'h005A, got);
    check_val("ds1_valid", 32'(out_valid[1]), 1);
    check_val("ds1_data", 32'(out_data[15:8]), 32'h5A);
    run_op(1, 16'hFE0E, 16'h005B, got);
    check_val("ds1_drop", 32'(out_data[15:8]), 32'h5A);
    drain(1);
    run_op(0, 16'hFE0C, 0, got); check_val("dsr1_ready", 32'(got), 32'h8000);

    // Keyboard interrupt
    run_op(1, 16'hFE00, 16'h4000, got);
    in_valid[0] = 1'b1; in_data[7:0] = 8'h55;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    m_kb_rdy[0] = 1; m_kbdr[0] = 8'h55;
    check_val("irq_lag", 32'(irq[0]), 0);
    @(posedge clk); #1;
    check_val("irq_set", 32'(irq[0]), 1);
    run_op(0, 16'hFE02, 0, got); check_val("kbdr_irq_char", 32'(got), 32'h0055);
    check_val("irq_clr", 32'(irq[0]), 0);

    // KBDR read while a new char is offered: accepted only after the clear
    inject(0, 8'h61);
    in_valid[0] = 1'b1; in_data[7:0] = 8'h62;
    pend_ch = 0; pend_char = 8'h62;
    run_op(0, 16'hFE02, 0, got); check_val("kbdr_old", 32'(got), 32'h0061);
    run_op(0, 16'hFE02, 0, got); check_val("kbdr_new", 32'(got), 32'h0062);

    // Window edges
    run_op(0, 16'hFE10, 0, got);
    run_op(0, 16'hFE08, 0, got); check_val("kbsr1", 32'(got), 32'h0000);

    // Reset in the middle of a memory write
    mio_en = 1'b1; rw = 1'b1; mar = 16'h3000; mdr = 16'hBEEF;
    @(posedge clk); #1;
    check_val("abort_mem_en_pre", 32'(mem_en), 1);
    rst_n = 1'b0;
    #1;
    check_val("abort_mem_en", 32'(mem_en), 0);
    mio_en = 1'b0;
    saw_r = 0;
    repeat (3) begin @(posedge clk); #1; saw_r |= r_out; end
    check_val("abort_no_r", 32'(saw_r), 0);
    rst_n = 1'b1;
    model_reset();
    check_val("abort_mem_kept", 32'(tb_mem[16'h3000]), 32'h1234);
    run_op(0, 16'hFE04, 0, got); check_val("dsr0_after_rst", 32'(got), 32'h8000);
    run_op(0, 16'h3000, 0, got);

    // Randomized mix
    for (int it = 0; it < 250; it++) begin
      int op, ch;
      logic [15:0] a;
      op = int'($urandom_range(0, 5));
      ch = int'($urandom_range(0, NC - 1));
      if ($urandom_range(0, 3) == 0) a = 16'hFE10 + 16'($urandom_range(0, 15));
      else a = 16'h4000 + 16'($urandom_range(0, 7));
      case (op)
        0: run_op(1, a, 16'($urandom), got);
        1: run_op(0, a, 16'h0000, got);
        2: run_op(0, BASE + 16'(8 * ch) + 16'($urandom_range(0, 7)), 16'h0000, got);
        3: run_op(1, BASE + 16'(8 * ch) + 16'($urandom_range(0, 7)), 16'($urandom), got);
        4: inject(ch, 8'($urandom));
        default: drain(ch);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
